fft_feed_adapter: RTL

// Single-clock stage directly downstream of input_buffer, in the source_clk domain.

---
 rtl/fft_feed_adapter_pkg.sv | 29 ++
 rtl/fft_feed_adapter_if.sv | 29 ++
 rtl/fft_feed_adapter_sdp_ram.sv | 31 +++
 rtl/fft_feed_adapter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fft_feed_adapter_pkg.sv
// Shared types and helpers for the FFT feed adapter: write-side FSM states,
// pointer sizing and sample sign extension.
package fft_feed_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  localparam int unsigned DROP_W = 16;

  // One extra bit beyond the address lets full and empty be told apart.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] d, input int unsigned dw);
    logic [31:0] r;
    logic [4:0]  sb;
    r  = d;
    sb = 5'(dw - 1);
    for (int i = 0; i < 32; i++) begin
      if (32'(i) >= dw) r[i] = d[sb];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_feed_adapter_if.sv
// Avalon-ST style sink (no ready) and source (with ready) bundle plus the drop counter.
interface fft_feed_adapter_if #(
  parameter int DATA_WIDTH = 14,
  parameter int OUT_WIDTH  = 16
);
  import fft_feed_adapter_pkg::*;

  logic                  sink_valid;
  logic                  sink_sop;
  logic                  sink_eop;
  logic [DATA_WIDTH-1:0] sink_data;
  logic                  source_ready;
  logic                  source_valid;
  logic                  source_sop;
  logic                  source_eop;
  logic [OUT_WIDTH-1:0]  source_data;
  logic [DROP_W-1:0]     drop_count;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_data, source_ready,
    input  source_valid, source_sop, source_eop, source_data, drop_count
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_data, source_ready,
    output source_valid, source_sop, source_eop, source_data, drop_count
  );

endinterface

// File: rtl/fft_feed_adapter_sdp_ram.sv
// Simple dual-port RAM, one clock, registered read port; the read register
// holds its value while re_i is low and resets to zero.
module fft_feed_adapter_sdp_ram #(
  parameter int WIDTH = 14,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_feed_adapter.sv
// Stores whole validated packets and forwards them sign-extended; first beat 2 cycles
// after the committing eop, output held stable under ready backpressure.
module fft_feed_adapter
  import fft_feed_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int OUT_WIDTH  = 16,
  parameter int BATCH_SIZE = 2048,
  parameter int FIFO_DEPTH = 4096
) (
  input  logic clk,
  input  logic reset_n,
  fft_feed_adapter_if.slave bus
);

  localparam int unsigned PW = ptr_width(FIFO_DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned CW = $clog2(BATCH_SIZE + 1);
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] MAX_USED = PW'(FIFO_DEPTH - BATCH_SIZE);
  localparam logic [CW-1:0] LAST     = CW'(BATCH_SIZE - 1);

  wr_state_t         state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_q, commit_d;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     ocnt_q;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W:0]   drop_sum;
  logic [1:0]        drop_inc;
  logic [PW-1:0]     base;
  logic [PW-1:0]     used;
  logic              start;
  logic              we;
  logic              load;
  logic              valid_q, sop_q, eop_q;
  logic [DATA_WIDTH-1:0] rdata;

  // An abort rewinds to commit_q; a sop in the same cycle then starts from there.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    cnt_d    = cnt_q;
    drop_inc = 2'd0;
    we       = 1'b0;
    base     = wr_ptr_q;
    start    = 1'b0;
    used     = wr_ptr_q - rd_ptr_q;
    if (bus.sink_valid) begin
      case (state_q)
        IDLE: start = bus.sink_sop;
        PKT: begin
          if (bus.sink_sop) begin
            base     = commit_q;
            wr_ptr_d = commit_q;
            drop_inc = 2'd1;
            start    = 1'b1;
          end else if (bus.sink_eop) begin
            state_d = IDLE;
            if (cnt_q == LAST) begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + ONE;
              commit_d = wr_ptr_q + ONE;
            end else begin
              wr_ptr_d = commit_q;
              drop_inc = 2'd1;
            end
          end else if (cnt_q == LAST) begin
            wr_ptr_d = commit_q;
            drop_inc = 2'd1;
            state_d  = DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
            cnt_d    = cnt_q + CW'(1);
          end
        end
        DROP: begin
          if (bus.sink_sop)      start   = 1'b1;
          else if (bus.sink_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // A sop+eop beat can never be a full packet, so it is dropped on the spot.
      if (start) begin
        used     = base - rd_ptr_q;
        wr_ptr_d = base;
        if (bus.sink_eop) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = IDLE;
        end else if (used <= MAX_USED) begin
          we       = 1'b1;
          wr_ptr_d = base + ONE;
          cnt_d    = CW'(1);
          state_d  = PKT;
        end else begin
          drop_inc = drop_inc + 2'd1;
          state_d  = DROP;
        end
      end
    end
    drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(drop_inc);
    drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      commit_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // The RAM read register is the output data stage; load only when it is free or draining.
  assign load = (commit_q != rd_ptr_q) && (!valid_q || bus.source_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      ocnt_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else if (load) begin
      rd_ptr_q <= rd_ptr_q + ONE;
      valid_q  <= 1'b1;
      sop_q    <= (ocnt_q == '0);
      eop_q    <= (ocnt_q == LAST);
      ocnt_q   <= (ocnt_q == LAST) ? '0 : ocnt_q + CW'(1);
    end else if (bus.source_ready) begin
      valid_q  <= 1'b0;
    end
  end

  fft_feed_adapter_sdp_ram #(
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .we_i    (we),
    .waddr_i (base[AW-1:0]),
    .wdata_i (bus.sink_data),
    .re_i    (load),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  assign bus.source_valid = valid_q;
  assign bus.source_sop   = sop_q;
  assign bus.source_eop   = eop_q;
  assign bus.source_data  = OUT_WIDTH'(sext(32'(rdata), DATA_WIDTH));
  assign bus.drop_count   = drop_q;

endmodule
